// File: rtl/ee357_mcpu_cu_v2_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, state
// encodings and the encodings of the multi-bit datapath selects.
package ee357_mcpu_pkg;

  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR     = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BEQ     = 4'd8,
    S_JMP     = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_JAL     = 4'd12,
    S_BNE     = 4'd13,
    S_TRAP    = 4'd14,
    S_JR      = 4'd15
  } state_t;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] ALUB_B      = 2'b00;
  localparam logic [1:0] ALUB_4      = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_TGT = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;
  localparam logic [1:0] PCS_REG = 2'b11;

  localparam logic [1:0] RDST_RT  = 2'b00;
  localparam logic [1:0] RDST_RD  = 2'b01;
  localparam logic [1:0] RDST_R31 = 2'b10;

  localparam logic [1:0] MTOR_ALU = 2'b00;
  localparam logic [1:0] MTOR_MDR = 2'b01;
  localparam logic [1:0] MTOR_PC  = 2'b10;

  // States that wait on mem_ready and are therefore covered by the timeout.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/ee357_mcpu_cu_v2_if.sv
// Control-unit bus: instruction fields and memory ready in, datapath strobes
// out. master = control unit, slave = datapath/memory side.
interface ee357_mcpu_cu_v2_if #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
);
  logic [OP_W-1:0]    op;
  logic [OP_W-1:0]    func;
  logic               mem_ready;
  logic               pcw;
  logic               pcwc;
  logic               bne;
  logic               iord;
  logic               mr;
  logic               mw;
  logic               irw;
  logic               regw;
  logic [1:0]         mtor;
  logic [1:0]         rdst;
  logic               alusela;
  logic [1:0]         aluselb;
  logic [1:0]         aluop;
  logic               tw;
  logic [1:0]         pcs;
  logic               illegal_op;
  logic               mem_err;
  logic [STATE_W-1:0] state;

  modport master (
    input  op, func, mem_ready,
    output pcw, pcwc, bne, iord, mr, mw, irw, regw, mtor, rdst,
           alusela, aluselb, aluop, tw, pcs, illegal_op, mem_err, state
  );

  modport slave (
    output op, func, mem_ready,
    input  pcw, pcwc, bne, iord, mr, mw, irw, regw, mtor, rdst,
           alusela, aluselb, aluop, tw, pcs, illegal_op, mem_err, state
  );
endinterface

// File: rtl/ee357_mcpu_cu_v2_wait_timer.sv
// Saturating count of consecutive not-ready cycles in a memory state; flags a
// timeout when the limit is reached and memory is still not ready.
module ee357_mcpu_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  input  logic ready,
  output logic timeout
);
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {CW{1'b1}})) begin
      count <= count + CW'(1);
    end
  end

  // A ready in the limit cycle completes the access instead of trapping.
  assign timeout = (MAX_WAIT != 0) && inc && !ready && (count == CW'(MAX_WAIT));
endmodule

// File: rtl/ee357_mcpu_cu_v2.sv
// Second-generation multicycle MIPS control unit (Moore FSM with memory wait
// timeout). Define EE357_MCPU_JR_EN to add the JR state (encoding 15).
module ee357_mcpu_cu_v2
  import ee357_mcpu_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int MAX_WAIT = 15,
  parameter int STATE_W  = 4
) (
  input logic               clk,
  input logic               rst,
  ee357_mcpu_cu_v2_if.master cu
);
  state_t st;
  logic   in_mem, tmr_clear, tmr_inc, timeout;
  logic   op_lw, op_sw, op_rtype, op_beq, op_bne, op_j, op_jal, op_addi;
  logic   is_jr, legal;

  assign op_lw    = (cu.op == OP_W'(OPC_LW));
  assign op_sw    = (cu.op == OP_W'(OPC_SW));
  assign op_rtype = (cu.op == OP_W'(OPC_RTYPE));
  assign op_beq   = (cu.op == OP_W'(OPC_BEQ));
  assign op_bne   = (cu.op == OP_W'(OPC_BNE));
  assign op_j     = (cu.op == OP_W'(OPC_J));
  assign op_jal   = (cu.op == OP_W'(OPC_JAL));
  assign op_addi  = (cu.op == OP_W'(OPC_ADDI));
  assign legal    = op_lw | op_sw | op_rtype | op_beq | op_bne | op_j | op_jal | op_addi;

`ifdef EE357_MCPU_JR_EN
  assign is_jr = op_rtype && (cu.func == OP_W'(FN_JR));
`else
  assign is_jr = 1'b0;
`endif

  // Any ready in a memory state ends that state, so it also restarts the count.
  assign in_mem    = is_mem_state(st);
  assign tmr_inc   = in_mem && !cu.mem_ready;
  assign tmr_clear = !in_mem || cu.mem_ready;

  ee357_mcpu_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .inc     (tmr_inc),
    .ready   (cu.mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= S_FETCH;
    end else begin
      case (st)
        S_FETCH: begin
          if (timeout)           st <= S_TRAP;
          else if (cu.mem_ready) st <= S_DECODE;
        end
        S_DECODE: begin
          if (op_lw || op_sw)    st <= S_MEMADR;
          else if (is_jr)        st <= S_JR;
          else if (op_rtype)     st <= S_EXEC;
          else if (op_beq)       st <= S_BEQ;
          else if (op_bne)       st <= S_BNE;
          else if (op_j)         st <= S_JMP;
          else if (op_jal)       st <= S_JAL;
          else if (op_addi)      st <= S_ADDI_EX;
          else                   st <= S_FETCH;
        end
        S_MEMADR: begin
          if (op_lw)             st <= S_MEMRD;
          else if (op_sw)        st <= S_MEMWR;
          else                   st <= S_FETCH;
        end
        S_MEMRD: begin
          if (timeout)           st <= S_TRAP;
          else if (cu.mem_ready) st <= S_MEMWB;
        end
        S_MEMWR: begin
          if (timeout)           st <= S_TRAP;
          else if (cu.mem_ready) st <= S_FETCH;
        end
        S_EXEC:                  st <= S_RWB;
        S_ADDI_EX:               st <= S_ADDI_WB;
        S_TRAP:                  st <= S_TRAP;
        default:                 st <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    cu.pcw        = 1'b0;
    cu.pcwc       = 1'b0;
    cu.bne        = 1'b0;
    cu.iord       = 1'b0;
    cu.mr         = 1'b0;
    cu.mw         = 1'b0;
    cu.irw        = 1'b0;
    cu.regw       = 1'b0;
    cu.mtor       = MTOR_ALU;
    cu.rdst       = RDST_RT;
    cu.alusela    = 1'b0;
    cu.aluselb    = ALUB_B;
    cu.aluop      = ALUOP_ADD;
    cu.tw         = 1'b0;
    cu.pcs        = PCS_ALU;
    cu.illegal_op = 1'b0;
    cu.mem_err    = 1'b0;
    case (st)
      S_FETCH: begin
        // Held low while rst is asserted so reset never produces a PC/IR write.
        cu.mr      = 1'b1;
        cu.aluselb = ALUB_4;
        cu.pcs     = PCS_ALU;
        cu.pcw     = cu.mem_ready & rst;
        cu.irw     = cu.mem_ready & rst;
      end
      S_DECODE: begin
        cu.aluselb    = ALUB_IMM_SH;
        cu.tw         = 1'b1;
        cu.illegal_op = !legal;
      end
      S_MEMADR: begin
        cu.alusela = 1'b1;
        cu.aluselb = ALUB_IMM;
      end
      S_MEMRD: begin
        cu.iord = 1'b1;
        cu.mr   = 1'b1;
      end
      S_MEMWB: begin
        cu.regw = 1'b1;
        cu.mtor = MTOR_MDR;
        cu.rdst = RDST_RT;
      end
      S_MEMWR: begin
        cu.iord = 1'b1;
        cu.mw   = 1'b1;
      end
      S_EXEC: begin
        cu.alusela = 1'b1;
        cu.aluselb = ALUB_B;
        cu.aluop   = ALUOP_FUNC;
      end
      S_RWB: begin
        cu.regw = 1'b1;
        cu.rdst = RDST_RD;
        cu.mtor = MTOR_ALU;
      end
      S_BEQ, S_BNE: begin
        cu.pcwc    = 1'b1;
        cu.alusela = 1'b1;
        cu.aluop   = ALUOP_SUB;
        cu.pcs     = PCS_TGT;
        cu.bne     = (st == S_BNE);
      end
      S_JMP: begin
        cu.pcw = 1'b1;
        cu.pcs = PCS_JMP;
      end
      S_ADDI_EX: begin
        cu.alusela = 1'b1;
        cu.aluselb = ALUB_IMM;
        cu.aluop   = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        cu.regw = 1'b1;
        cu.rdst = RDST_RT;
        cu.mtor = MTOR_ALU;
      end
      S_JAL: begin
        cu.pcw  = 1'b1;
        cu.pcs  = PCS_JMP;
        cu.regw = 1'b1;
        cu.rdst = RDST_R31;
        cu.mtor = MTOR_PC;
      end
      S_TRAP: begin
        cu.mem_err = 1'b1;
      end
`ifdef EE357_MCPU_JR_EN
      S_JR: begin
        cu.pcw = 1'b1;
        cu.pcs = PCS_REG;
      end
`endif
      default: begin
      end
    endcase
  end

  assign cu.state = STATE_W'(st);
endmodule

// File: tb/tb_ee357_mcpu_cu_v2.sv
// Directed and randomized bench for ee357_mcpu_cu_v2: expected state traces
// are built per instruction and checked cycle by cycle against an output table.
module tb_ee357_mcpu_cu_v2;
  localparam int MAX_WAIT = 15;
`ifdef EE357_MCPU_JR_EN
  localparam bit JR_EN = 1'b1;
`else
  localparam bit JR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ee357_mcpu_cu_v2_if #(.OP_W(6), .STATE_W(4)) bus ();

  ee357_mcpu_cu_v2 #(.OP_W(6), .MAX_WAIT(MAX_WAIT), .STATE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .cu  (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;
  logic [3:0] exp_q[$];
  bit         rdy_q[$];

  logic [20:0] ctrl_obs;
  assign ctrl_obs = {bus.pcw, bus.pcwc, bus.bne, bus.iord, bus.mr, bus.mw, bus.irw,
                     bus.regw, bus.mtor, bus.rdst, bus.alusela, bus.aluselb,
                     bus.aluop, bus.tw, bus.pcs, bus.mem_err};

  // Control table by state number; r is mem_ready (only FETCH depends on it).
  function automatic logic [20:0] ctrl_of(input int s, input bit r);
    logic pcw, pcwc, bne, iord, mr, mw, irw, regw, alusela, tw, mem_err;
    logic [1:0] mtor, rdst, aluselb, aluop, pcs;
    {pcw, pcwc, bne, iord, mr, mw, irw, regw, alusela, tw, mem_err} = '0;
    {mtor, rdst, aluselb, aluop, pcs} = '0;
    case (s)
      0:  begin mr = 1; aluselb = 2'b01; pcw = r; irw = r; end
      1:  begin aluselb = 2'b11; tw = 1; end
      2:  begin alusela = 1; aluselb = 2'b10; end
      3:  begin iord = 1; mr = 1; end
      4:  begin regw = 1; mtor = 2'b01; end
      5:  begin iord = 1; mw = 1; end
      6:  begin alusela = 1; aluop = 2'b10; end
      7:  begin regw = 1; rdst = 2'b01; end
      8:  begin pcwc = 1; alusela = 1; aluop = 2'b01; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin alusela = 1; aluselb = 2'b10; end
      11: begin regw = 1; end
      12: begin pcw = 1; pcs = 2'b10; regw = 1; rdst = 2'b10; mtor = 2'b10; end
      13: begin pcwc = 1; bne = 1; alusela = 1; aluop = 2'b01; pcs = 2'b01; end
      14: begin mem_err = 1; end
      15: begin pcw = 1; pcs = 2'b11; end
      default: begin end
    endcase
    return {pcw, pcwc, bne, iord, mr, mw, irw, regw, mtor, rdst, alusela,
            aluselb, aluop, tw, pcs, mem_err};
  endfunction

  function automatic bit legal_op(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                      6'b000101, 6'b000010, 6'b001000, 6'b000011};
  endfunction

  task automatic check(input int s, input bit r, input bit ill, input string tag);
    n_checks++;
    assert (bus.state === 4'(s)) else begin
      n_fails++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, bus.state, s);
    end
    n_checks++;
    assert (ctrl_obs === ctrl_of(s, r)) else begin
      n_fails++;
      $error("FAIL %s ctrl(state %0d) observed=%h expected=%h", tag, s, ctrl_obs, ctrl_of(s, r));
    end
    n_checks++;
    assert (bus.illegal_op === ill) else begin
      n_fails++;
      $error("FAIL %s illegal_op(state %0d) observed=%b expected=%b", tag, s, bus.illegal_op, ill);
    end
  endtask

  // Memory states wait `stall` not-ready cycles, then see ready once.
  task automatic push_state(input int s, input int stall);
    if (s == 0 || s == 3 || s == 5) begin
      for (int k = 0; k < stall; k++) begin
        exp_q.push_back(4'(s));
        rdy_q.push_back(1'b0);
      end
      exp_q.push_back(4'(s));
      rdy_q.push_back(1'b1);
    end else begin
      exp_q.push_back(4'(s));
      rdy_q.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] func,
                           input int fs, input int ms, input string tag);
    int s;
    exp_q.delete();
    rdy_q.delete();
    push_state(0, fs);
    push_state(1, 0);
    case (op)
      6'b100011: begin push_state(2, 0); push_state(3, ms); push_state(4, 0); end
      6'b101011: begin push_state(2, 0); push_state(5, ms); end
      6'b000000: begin
        if (JR_EN && func == 6'b001000) push_state(15, 0);
        else begin push_state(6, 0); push_state(7, 0); end
      end
      6'b000100: push_state(8, 0);
      6'b000101: push_state(13, 0);
      6'b000010: push_state(9, 0);
      6'b000011: push_state(12, 0);
      6'b001000: begin push_state(10, 0); push_state(11, 0); end
      default: begin end
    endcase
    while (exp_q.size() != 0) begin
      s = int'(exp_q.pop_front());
      @(negedge clk);
      bus.mem_ready = rdy_q.pop_front();
      if (s == 1 || s == 2) begin
        bus.op   = op;
        bus.func = func;
      end else begin
        bus.op   = 6'($urandom);
        bus.func = 6'($urandom);
      end
      #1;
      check(s, bus.mem_ready, (s == 1) && !legal_op(op), tag);
    end
  endtask

  // Release just after a rising edge so FETCH starts with a fresh wait count.
  task automatic do_reset(input string tag);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    check(0, 1'b0, 1'b0, tag);
    @(negedge clk);
    #1;
    check(0, 1'b0, 1'b0, tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [9];
    logic [5:0] rop, rfn;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
            6'b000010, 6'b000011, 6'b001000, 6'b111111};
    rst = 1'b1;
    bus.op = 6'b100011;
    bus.func = 6'b000000;
    bus.mem_ready = 1'b1;
    #2;
    do_reset("reset");

    run_instr(6'b100011, 6'd0, 0, 0, "lw");
    run_instr(6'b000011, 6'd0, 0, 0, "jal");
    run_instr(6'b000101, 6'd0, 0, 0, "bne");
    run_instr(6'b000100, 6'd0, 0, 0, "beq");
    run_instr(6'b000010, 6'd0, 0, 0, "j");
    run_instr(6'b001000, 6'd0, 0, 0, "addi");
    run_instr(6'b111111, 6'd0, 0, 0, "illegal");
    run_instr(6'b000000, 6'b100000, 0, 0, "rtype");
    run_instr(6'b000000, 6'b001000, 0, 0, "jr_func");
    run_instr(6'b101011, 6'd0, 0, 3, "sw_stall3");
    run_instr(6'b100011, 6'd0, 15, 15, "ready_at_limit");

    // Sixteen not-ready cycles in FETCH trap; TRAP ignores inputs until reset.
    do_reset("reset_pre_trap");
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.op = 6'b100011;
      #1;
      check(0, 1'b0, 1'b0, "fetch_wait");
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      check(14, bus.mem_ready, 1'b0, "trap_sticky");
    end
    do_reset("reset_from_trap");

    // Asynchronous reset in the middle of a store drops mw at once.
    run_instr(6'b000010, 6'd0, 0, 0, "j_before_abort");
    exp_q.delete();
    @(negedge clk); bus.mem_ready = 1'b1; #1; check(0, 1'b1, 1'b0, "abort_fetch");
    @(negedge clk); bus.op = 6'b101011; #1; check(1, bus.mem_ready, 1'b0, "abort_decode");
    @(negedge clk); #1; check(2, bus.mem_ready, 1'b0, "abort_memadr");
    @(negedge clk); bus.mem_ready = 1'b0; #1; check(5, 1'b0, 1'b0, "abort_memwr");
    #2;
    rst = 1'b0;
    #1;
    check(0, 1'b0, 1'b0, "abort_reset");
    do_reset("abort_reset_hold");

    for (int n = 0; n < 30; n++) begin
      rop = ops[$urandom_range(0, 8)];
      rfn = ($urandom_range(0, 2) == 0) ? 6'b001000 : 6'($urandom);
      run_instr(rop, rfn, $urandom_range(0, 4), $urandom_range(0, 4), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/ee357_mcpu_cu_v2.md
Name: ee357_mcpu_cu_v2

Overview:
Second-generation multicycle MIPS control unit. Moore FSM that drives the datapath control strobes. Beyond the first-generation LW/SW/R-type/BEQ/J flow it adds:
- ADDI, BNE and JAL.
- A memory-ready wait handshake with a parametrised timeout and a trap state.
- Illegal-opcode flagging.
Sits between the instruction register (op/func) and the multicycle datapath and memory.

Parameters:
OP_W, 6, opcode and func field width
MAX_WAIT, 15, maximum consecutive mem_ready=0 cycles tolerated in a memory state; 0 disables the timeout
STATE_W, 4, state register width

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset; asynchronous, active-low (asserted at 0)
op  in  OP_W  instruction opcode
func  in  OP_W  R-type function field
mem_ready  in  1  memory acknowledge for the current access
pcw  out  1  PCWrite
pcwc  out  1  PCWriteCond
bne  out  1  invert zero flag for the conditional PC write
iord  out  1  0=PC address, 1=ALUOut address
mr  out  1  MemRead
mw  out  1  MemWrite
irw  out  1  IRWrite
regw  out  1  RegWrite
mtor  out  2  register write data: 00 ALUOut, 01 MDR, 10 PC
rdst  out  2  destination register: 00 rt, 01 rd, 10 r31
alusela  out  1  0=PC, 1=A
aluselb  out  2  00 B, 01 const 4, 10 sign-extended imm, 11 imm<<2
aluop  out  2  00 add, 01 sub, 10 func-decoded
tw  out  1  TargetWrite
pcs  out  2  00 ALU, 01 Target, 10 jump address, 11 register A (JR only)
illegal_op  out  1  unsupported opcode seen in DECODE
mem_err  out  1  memory timeout trap, sticky
state  out  STATE_W  current state (debug)

Behaviour:
- Output coding: all outputs are decoded from the state register. Any output not listed for a state is 0.
- Reset (rst=0, asynchronous): state=FETCH, the wait counter clears, mem_err=0. Outputs take FETCH values, with pcw/irw gated by mem_ready.
- States and outputs:
  - FETCH (0): mr=1, aluselb=01, pcs=00; pcw=irw=mem_ready. Stays until mem_ready=1, then goes to DECODE.
  - DECODE (1): aluselb=11, tw=1. Next state by op:
    - LW/SW → MEMADR
    - R-type → EXEC
    - BEQ → BEQ
    - BNE → BNE
    - J → JMP
    - JAL → JAL
    - ADDI → ADDI_EX
    - other → FETCH, with illegal_op=1 for this cycle only.
  - MEMADR (2): alusela=1, aluselb=10. LW → MEMRD; SW → MEMWR.
  - MEMRD (3): iord=1, mr=1. Stays until mem_ready, then goes to MEMWB.
  - MEMWB (4): regw=1, mtor=01, rdst=00. Then FETCH.
  - MEMWR (5): iord=1, mw=1. Stays until mem_ready, then goes to FETCH.
  - EXEC (6): alusela=1, aluselb=00, aluop=10. Then RWB.
  - RWB (7): regw=1, rdst=01, mtor=00. Then FETCH.
  - BEQ (8): pcwc=1, alusela=1, aluop=01, pcs=01. Then FETCH.
  - JMP (9): pcw=1, pcs=10. Then FETCH.
  - ADDI_EX (10): alusela=1, aluselb=10, aluop=00. Then ADDI_WB.
  - ADDI_WB (11): regw=1, rdst=00, mtor=00. Then FETCH.
  - JAL (12): pcw=1, pcs=10, regw=1, rdst=10, mtor=10. Writes the already-incremented PC to r31. Then FETCH.
  - BNE (13): same outputs as BEQ plus bne=1. Then FETCH.
  - TRAP (14): all strobes 0, mem_err=1. Only reset exits TRAP.
  - Encoding 15: unused; next state FETCH.
- Wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle with mem_ready=0.
  - If MAX_WAIT≠0, count==MAX_WAIT and mem_ready=0 → TRAP.
  - mem_ready=1 in the same cycle as count==MAX_WAIT completes normally (ready wins).
  - The counter saturates and does not wrap.
- op/func are sampled only in DECODE and MEMADR. Changes in other states have no effect.
- Reset asserted mid-instruction abandons it immediately. No write strobe is asserted after rst falls.

Optional Feature:
Macro EE357_MCPU_JR_EN.
- Defined: in DECODE, R-type with func=001000 goes to JR (state 15): pcw=1, pcs=11, then FETCH. No register write occurs.
- Undefined: state 15 behaves as unused, pcs=11 is never driven, and func=001000 follows the normal R-type EXEC/RWB path.

Decomposition:
- Package ee357_mcpu_pkg holds:
  - opcode constants (LW 100011, SW 101011, RTYPE 000000, BEQ 000100, BNE 000101, J 000010, ADDI 001000, JAL 000011) and func JR 001000
  - state encodings
  - aluop, aluselb, pcs, rdst and mtor encodings.
- Sub-module ee357_mcpu_wait_timer (MAX_WAIT param): clear, inc, ready in; timeout out.

Test Plan:
- Reset low then high with mem_ready=1, op=LW, run 5 clocks: FETCH (pcw=1, mr=1, irw=1, aluselb=01) → DECODE (aluselb=11, tw=1) → MEMADR → MEMRD → MEMWB (regw=1, mtor=01) → FETCH.
- op=JAL: JAL state shows pcw=1, pcs=10, regw=1, rdst=10, mtor=10. op=BNE: pcwc=1, bne=1, aluop=01, pcs=01.
- op=ADDI: ADDI_EX (alusela=1, aluselb=10, aluop=00) → ADDI_WB (regw=1, rdst=00). op=111111: illegal_op=1 for one DECODE cycle, then FETCH.
- SW with mem_ready=0 for 3 cycles in MEMWR: mw held at 1 for 4 cycles, state stays 5, then FETCH.
- MAX_WAIT=15 with mem_ready held 0 in FETCH: TRAP after the 16th waiting cycle, mem_err=1 and stays; rst=0 restores FETCH and mem_err=0. A run with ready arriving on cycle 16 exactly must complete normally.
- With EE357_MCPU_JR_EN: op=0, func=001000 → state 15, pcw=1, pcs=11, no regw. Without the macro: EXEC/RWB with rdst=01.
